// File: rtl/nios_dbg_pkg.sv
// Shared types and constants for the Nios II debug slave, system-clock half.
package nios_dbg_pkg;

  // Command-execution FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_ACK = 2'd2
  } dbg_state_e;

  // Widths used by the standard debug slave wrapper
  localparam int DEF_SR_W = 38;
  localparam int DEF_IR_W = 2;

  // Virtual-JTAG IR channel assignments
  localparam int CH_OCIMEM = 0;
  localparam int CH_BREAK  = 2;
  localparam int CH_TRACE  = 3;

endpackage

// File: rtl/nios_dbg_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by a registered
// rising-edge detector: one single-cycle pulse per level pulse, appearing
// STAGES+1 clk edges after the level rises.
module nios_dbg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_d;

  // Shift the level through the synchroniser and register its rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      last_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], level};
      last_d <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~last_d;
    end
  end

endmodule

// File: rtl/nios_debug_slave_sysclk_multi.sv
// System-clock half of the Nios II JTAG debug slave. Brings update-IR and
// exit1-DR across from TCK, queues captured scans, and turns each queued
// command into a one-cycle take_action / take_no_action strobe on its IR
// channel, optionally waiting for an acknowledge with a timeout.
module nios_debug_slave_sysclk_multi
  import nios_dbg_pkg::*;
#(
  parameter int                       SR_W        = DEF_SR_W,
  parameter int                       IR_W        = DEF_IR_W,
  parameter int                       SYNC_STAGES = 2,
  parameter int                       FIFO_DEPTH  = 4,
  parameter logic [(2**IR_W)-1:0]     ACK_MASK    = 'b0011,
  parameter int                       TIMEOUT     = 255,
  parameter int                       MODE_BIT    = SR_W - 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [SR_W-1:0]                      sr,
  input  logic [IR_W-1:0]                      ir_in,
  input  logic                                 vs_uir,
  input  logic                                 vs_e1dr,
  input  logic                                 act_ack,
  input  logic                                 clr_status,
  output logic [SR_W-1:0]                      jdo,
  output logic [IR_W-1:0]                      jir,
  output logic [(2**IR_W)-1:0]                 take_action,
  output logic [(2**IR_W)-1:0]                 take_no_action,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overflow,
  output logic                                 timeout
);

  localparam int CH = 2**IR_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int CW = $clog2(TIMEOUT+1);
  localparam int EW = SR_W + IR_W;

  logic uir_evt;
  logic e1dr_evt;

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_uir),
    .rise    (uir_evt)
  );

  nios_dbg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_e1dr (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (vs_e1dr),
    .rise    (e1dr_evt)
  );

  logic [IR_W-1:0] ir_q;

  // Capture the IR on each update-IR event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= '0;
    end else if (uir_evt) begin
      ir_q <= ir_in;
    end
  end

  // Command FIFO
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic [EW-1:0]   push_data;
  logic [EW-1:0]   head;
  logic [IR_W-1:0] head_ir;
  logic            head_mode;
  logic [CH-1:0]   head_onehot;

  dbg_state_e      state;
  logic [CW-1:0]   cnt;

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a push when the FSM frees a slot the same cycle
  assign push       = e1dr_evt && (!fifo_full || pop);
  // A coincident update-IR must tag this scan with the IR just shifted in
  assign push_data  = {(uir_evt ? ir_in : ir_q), sr};

  assign head        = mem[rd_ptr];
  assign head_ir     = head[SR_W +: IR_W];
  assign head_mode   = head[MODE_BIT];
  assign head_onehot = CH'(1) << head_ir;

  assign fifo_level = level_q;
  assign busy       = (state != IDLE);

  // FIFO storage write; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (e1dr_evt && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_status) begin
        overflow <= 1'b0;
      end
    end
  end

  // Command FSM: pop, strobe the channel, optionally wait for act_ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      jdo            <= '0;
      jir            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      cnt            <= '0;
      timeout        <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      // A timeout raised below in the same cycle overrides this clear
      if (clr_status) begin
        timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            jdo <= head[SR_W-1:0];
            jir <= head_ir;
            if (head_mode) begin
              take_action <= head_onehot;
            end else begin
              take_no_action <= head_onehot;
            end
            state <= STROBE;
          end
        end
        STROBE: begin
          if (ACK_MASK[jir]) begin
            cnt   <= CW'(1);
            state <= WAIT_ACK;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_ACK: begin
          if (act_ack) begin
            state <= IDLE;
          end else if (cnt == CW'(TIMEOUT)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_debug_slave_sysclk_multi.sv
// Bench for nios_debug_slave_sysclk_multi: directed scans with a scoreboard
// of expected commands checked whenever a strobe appears.
module tb_nios_debug_slave_sysclk_multi;
  import nios_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_uir;
  logic        vs_e1dr;
  logic        act_ack;
  logic        clr_status;
  logic [37:0] jdo;
  logic [1:0]  jir;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        timeout;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] sr;
  } cmd_t;

  cmd_t        sb[$];
  logic [1:0]  model_ir;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobe_cnt = 0;

  nios_debug_slave_sysclk_multi #(
    .SR_W(38), .IR_W(2), .SYNC_STAGES(2), .FIFO_DEPTH(4),
    .ACK_MASK(4'b0011), .TIMEOUT(255), .MODE_BIT(34)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_uir         (vs_uir),
    .vs_e1dr        (vs_e1dr),
    .act_ack        (act_ack),
    .clr_status     (clr_status),
    .jdo            (jdo),
    .jir            (jir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .busy           (busy),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk(input logic mode, input logic [31:0] lo);
    return {3'b101, mode, 2'b11, lo};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_uir(input logic [1:0] ir);
    ir_in    = ir;
    model_ir = ir;
    vs_uir   = 1'b1;
    tick(4);
    vs_uir   = 1'b0;
    tick(3);
  endtask

  task automatic do_scan(input logic [37:0] v, input bit expect_it);
    cmd_t c;
    sr = v;
    if (expect_it) begin
      c.ir = model_ir;
      c.sr = v;
      sb.push_back(c);
    end
    vs_e1dr = 1'b1;
    tick(4);
    vs_e1dr = 1'b0;
    tick(2);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ta"},   64'(take_action), 64'd0);
    check_eq({tag, "_tna"},  64'(take_no_action), 64'd0);
    check_eq({tag, "_jdo"},  64'(jdo), 64'd0);
    check_eq({tag, "_jir"},  64'(jir), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_lvl"},  64'(fifo_level), 64'd0);
    check_eq({tag, "_ovf"},  64'(overflow), 64'd0);
    check_eq({tag, "_tmo"},  64'(timeout), 64'd0);
  endtask

  // Scoreboard: every strobe must match the oldest expected command
  always @(negedge clk) begin
    cmd_t       e;
    logic [3:0] oh;
    if (reset_n && ((take_action | take_no_action) != 4'b0)) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        check_eq("sb_unexpected", 64'({take_action, take_no_action}), 64'd0);
      end else begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.ir;
        check_eq("sb_jir", 64'(jir), 64'(e.ir));
        check_eq("sb_jdo", 64'(jdo), 64'(e.sr));
        check_eq("sb_strobe", 64'({take_action, take_no_action}),
                 e.sr[34] ? 64'({oh, 4'b0000}) : 64'({4'b0000, oh}));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [37:0] v;
    cmd_t        c;
    int          n;
    int          sc;

    reset_n = 1'b0; sr = '0; ir_in = '0; vs_uir = 1'b0; vs_e1dr = 1'b0;
    act_ack = 1'b0; clr_status = 1'b0; model_ir = '0;
    tick(3);
    check_all_zero("rst");
    reset_n = 1'b1;
    tick(2);

    // Unacked channel: exact latency and single-cycle strobe
    do_uir(2'(CH_BREAK));
    v = mk(1'b1, 32'hCAFE_BEEF);
    sr = v;
    c.ir = 2'(CH_BREAK); c.sr = v;
    sb.push_back(c);
    vs_e1dr = 1'b1;
    tick(4);
    check_eq("t1_level", 64'(fifo_level), 64'd1);
    tick(1);
    check_eq("t1_ta", 64'(take_action), 64'h4);
    check_eq("t1_jdo", 64'(jdo), 64'(v));
    check_eq("t1_jir", 64'(jir), 64'd2);
    check_eq("t1_busy", 64'(busy), 64'd1);
    tick(1);
    check_eq("t1_ta_off", 64'(take_action), 64'd0);
    check_eq("t1_busy_off", 64'(busy), 64'd0);
    vs_e1dr = 1'b0;
    tick(3);

    // Acked channel 0 with an ack after 5 cycles
    do_uir(2'(CH_OCIMEM));
    do_scan(mk(1'b0, 32'h0000_1111), 1'b1);
    check_eq("t2_busy", 64'(busy), 64'd1);
    tick(4);
    check_eq("t2_busy_held", 64'(busy), 64'd1);
    act_ack = 1'b1;
    tick(1);
    act_ack = 1'b0;
    check_eq("t2_idle", 64'(busy), 64'd0);
    check_eq("t2_tmo", 64'(timeout), 64'd0);

    // No ack: busy for strobe + TIMEOUT cycles, then sticky timeout
    do_scan(mk(1'b0, 32'h0000_2222), 1'b1);
    n = 2;
    while (busy && n < 400) begin
      tick(1);
      if (busy) n++;
    end
    check_eq("t3_busy_cycles", 64'(n), 64'd256);
    check_eq("t3_tmo", 64'(timeout), 64'd1);
    tick(3);
    check_eq("t3_tmo_sticky", 64'(timeout), 64'd1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check_eq("t3_tmo_clr", 64'(timeout), 64'd0);

    // clr_status coincident with a new timeout: set wins
    do_scan(mk(1'b0, 32'h0000_3333), 1'b1);
    tick(254);
    check_eq("t3b_busy", 64'(busy), 64'd1);
    check_eq("t3b_tmo_pre", 64'(timeout), 64'd0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check_eq("t3b_tmo_set", 64'(timeout), 64'd1);
    check_eq("t3b_idle", 64'(busy), 64'd0);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check_eq("t3b_tmo_clr", 64'(timeout), 64'd0);

    // Overflow: stall on an acked command, then queue 6 scans into 4 slots
    do_scan(mk(1'b1, 32'h0000_4444), 1'b1);
    do_uir(2'(CH_BREAK));
    for (int k = 0; k < 6; k++) begin
      do_scan(mk(k[0], 32'hA000_0000 + 32'(k)), k < 4);
      if (k == 3) check_eq("t4_no_ovf_yet", 64'(overflow), 64'd0);
    end
    check_eq("t4_level", 64'(fifo_level), 64'd4);
    check_eq("t4_ovf", 64'(overflow), 64'd1);
    check_eq("t4_busy", 64'(busy), 64'd1);
    sc = strobe_cnt;
    act_ack = 1'b1;
    tick(1);
    act_ack = 1'b0;
    tick(12);
    check_eq("t4_strobes", 64'(strobe_cnt - sc), 64'd4);
    check_eq("t4_sb_empty", 64'(sb.size()), 64'd0);
    check_eq("t4_level_end", 64'(fifo_level), 64'd0);
    check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);
    clr_status = 1'b1;
    tick(1);
    clr_status = 1'b0;
    check_eq("t4_ovf_clr", 64'(overflow), 64'd0);

    // Coincident update-IR and exit1-DR: new IR tags the command
    v = mk(1'b1, 32'h5555_0003);
    ir_in = 2'(CH_TRACE);
    sr = v;
    c.ir = 2'(CH_TRACE); c.sr = v;
    sb.push_back(c);
    sc = strobe_cnt;
    vs_uir = 1'b1;
    vs_e1dr = 1'b1;
    tick(4);
    vs_uir = 1'b0;
    vs_e1dr = 1'b0;
    tick(4);
    model_ir = 2'(CH_TRACE);
    check_eq("t5_strobes", 64'(strobe_cnt - sc), 64'd1);
    check_eq("t5_jir", 64'(jir), 64'd3);
    check_eq("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset during WAIT_ACK with two commands queued
    do_uir(2'(CH_OCIMEM));
    do_scan(mk(1'b1, 32'h7777_0000), 1'b1);
    do_scan(mk(1'b1, 32'h7777_0001), 1'b0);
    do_scan(mk(1'b0, 32'h7777_0002), 1'b0);
    check_eq("t6_level", 64'(fifo_level), 64'd2);
    check_eq("t6_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    tick(2);
    reset_n = 1'b1;
    model_ir = '0;
    sc = strobe_cnt;
    tick(20);
    check_eq("t6_no_strobe", 64'(strobe_cnt - sc), 64'd0);
    check_eq("t6_level_end", 64'(fifo_level), 64'd0);
    check_eq("t6_busy_end", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_debug_slave_sysclk_multi.md
Name: nios_debug_slave_sysclk_multi

Overview:
- System-clock half of the Nios II JTAG debug slave, parametrised successor of the fixed 38-bit/2-bit-IR sysclk block.
- Synchronises the TCK-domain update-IR/exit1-DR levels into clk and queues captured scans in a small command FIFO.
- Decodes each command into per-IR-channel one-cycle take_action / take_no_action strobes.
- Adds an optional ack handshake with timeout per channel, plus sticky overflow/timeout status for the OCI.

Parameters:
SR_W, 38, width of the JTAG data shift register (sr/jdo).
IR_W, 2, virtual-JTAG IR width; channel count CH = 2**IR_W.
SYNC_STAGES, 2, synchroniser depth for vs_uir/vs_e1dr (min 2).
FIFO_DEPTH, 4, command FIFO entries (power of 2, min 2).
ACK_MASK, 4'b0011, bit c set = channel c waits for act_ack after its strobe.
TIMEOUT, 255, max clk cycles waited for act_ack (min 1).
MODE_BIT, SR_W-4, jdo bit selecting take_action (1) vs take_no_action (0).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
sr  in  SR_W  TCK-domain shift register; stable while vs_e1dr high
ir_in  in  IR_W  TCK-domain IR; stable while vs_uir high
vs_uir  in  1  update-IR level, asynchronous to clk
vs_e1dr  in  1  exit1-DR level, asynchronous to clk
act_ack  in  1  monitor acknowledges current action
clr_status  in  1  clears overflow/timeout sticky bits
jdo  out  SR_W  data of the command being executed
jir  out  IR_W  IR of the command being executed
take_action  out  CH  one-hot 1-cycle strobe, channel = jir
take_no_action  out  CH  one-hot 1-cycle strobe, channel = jir
busy  out  1  FSM not IDLE
fifo_level  out  $clog2(FIFO_DEPTH+1)  queued commands
overflow  out  1  sticky: e1dr event dropped, FIFO full
timeout  out  1  sticky: ack wait expired

Behaviour:
- Reset: all synchroniser flops, ir_q, FIFO pointers, jdo, jir, strobes, busy, overflow, timeout = 0; fifo_level = 0; FSM = IDLE. Asynchronous reset mid-operation aborts any command and drops the queue.
- Sync: each level passes through SYNC_STAGES flops. An event is a rising edge of the last stage versus its one-cycle delayed copy, i.e. one event per level pulse. Latency from level to event is SYNC_STAGES+1 clk.
- uir event: ir_q <= ir_in.
- e1dr event: push {ir_q, sr} into the FIFO. If uir and e1dr events coincide, the newly captured ir_in is pushed, not the old ir_q.
- FIFO full on push: if a pop also occurs that cycle, the push is accepted. Otherwise the push is dropped and overflow <= 1.
- FSM IDLE: if the FIFO is non-empty, pop into {jir, jdo} and go to STROBE (1 cycle after the push at the earliest).
- FSM STROBE (1 cycle): assert exactly one bit, take_action[jir] if jdo[MODE_BIT] else take_no_action[jir].
  - Next state is WAIT_ACK if ACK_MASK[jir], else IDLE.
  - Back-to-back unacked commands produce strobes every 2 cycles.
- FSM WAIT_ACK: count cycles from 1.
  - act_ack -> IDLE; ack in the same cycle as count==TIMEOUT counts as ack.
  - count==TIMEOUT without ack -> timeout <= 1, IDLE.
  - act_ack outside WAIT_ACK is ignored.
- jdo/jir hold their value until the next pop.
- busy = (state != IDLE).
- fifo_level updates the cycle after push/pop; simultaneous push+pop leaves it unchanged.
- Sticky bits: clr_status clears them. A set condition in the same cycle as clr_status wins (bit stays 1).
- Configuration from the debug slave wrapper: SR_W=38, IR_W=2, channel 0 = ocimem, 2 = break, 3 = tracectrl.

Decomposition:
- Package nios_dbg_pkg: FSM state enum (IDLE, STROBE, WAIT_ACK), default SR_W/IR_W constants, channel index constants (CH_OCIMEM=0, CH_BREAK=2, CH_TRACE=3).
- One sub-module, nios_dbg_sync_edge: a SYNC_STAGES synchroniser plus rising-edge detector, instantiated twice.
- FIFO and FSM stay inline.

Test Plan:
- Reset, then pulse vs_uir with ir_in=2'b10, then vs_e1dr with sr[34]=1 -> after 2+1+1+1 clk, take_action=4'b0100 for exactly one cycle, jdo=sr, jir=2, busy low the next cycle.
- ir_in=0, sr[34]=0, ACK_MASK[0]=1 -> take_no_action[0] pulses, busy held; act_ack after 5 cycles -> IDLE, timeout=0.
- Same command with no ack, TIMEOUT=255 -> busy for 1+255 cycles, then timeout=1. clr_status clears it; clr_status coincident with a new timeout leaves timeout=1.
- Stall with ack withheld; issue 6 e1dr events with FIFO_DEPTH=4 -> fifo_level saturates at 4, overflow=1, and after acks exactly 4 more strobes occur, in push order.
- vs_uir and vs_e1dr rising together with ir_in=3 -> the queued command has jir=3.
- Assert reset_n low during WAIT_ACK with 2 commands queued -> all outputs 0 immediately; no strobe after release.
